// File: rtl/seq_counting_pkg.sv
// Shared constants and helpers for the ascending-run detector.
// State encoding: MATCH_k is the integer k, DONE is the integer LEN.
package seq_counting_pkg;
  localparam int SYM_START = 1;

  function automatic int prog_w(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

  function automatic int done_code(input int len);
    return len;
  endfunction
endpackage

// File: rtl/seq_counting_if.sv
// Symbol stream in, match status out.
interface seq_counting_if
  import seq_counting_pkg::*;
#(
  parameter int W     = 2,
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) ();
  logic                     en;
  logic [W-1:0]             num;
  logic                     clr;
  logic                     ans;
  logic                     hit;
  logic [CNT_W-1:0]         count;
  logic [prog_w(LEN)-1:0]   progress;

  modport master (output en, num, clr, input ans, hit, count, progress);
  modport slave  (input en, num, clr, output ans, hit, count, progress);
endinterface

// File: rtl/seq_counting_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              q <= '0;
    else if (clr)                           q <= '0;
    else if (inc && (q != {CNT_W{1'b1}}))   q <= q + CNT_W'(1);
  end
endmodule

// File: rtl/seq_counting.sv
// Detects the run 1,2,...,LEN on a qualified symbol stream; sticky or counting.
module seq_counting
  import seq_counting_pkg::*;
#(
  parameter int W      = 2,
  parameter int LEN    = 3,
  parameter int CNT_W  = 8,
  parameter bit STICKY = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  seq_counting_if.slave bus
);
  localparam int PW = prog_w(LEN);
  localparam logic [PW-1:0] DONE_S = PW'(done_code(LEN));

  if (LEN < 1 || LEN > 2**W - 1) begin : g_bad_len
    $error("seq_counting: LEN must be in 1..2**W-1");
  end

  logic [PW-1:0] state, nxt;
  logic          match;
  logic          hit_q;
  logic          ans_d;
  logic [PW-1:0] prog_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= '0;
      hit_q <= 1'b0;
    end else begin
      state <= nxt;
      hit_q <= match;
    end
  end

  // Any mismatch falls back to MATCH_1 or MATCH_0 only: no proper suffix
  // of 1..LEN other than "1" is also a prefix of it.
  always_comb begin
    nxt   = state;
    match = 1'b0;
    if (bus.clr) begin
      nxt = '0;
    end else if (bus.en && !(STICKY && state == DONE_S)) begin
      if (int'(bus.num) == int'(state) + 1) begin
        if (int'(state) + 1 == LEN) begin
          match = 1'b1;
          nxt   = STICKY ? DONE_S : '0;
        end else begin
          nxt = PW'(int'(state) + 1);
        end
      end else if (int'(bus.num) == SYM_START) begin
        nxt = PW'(1);
      end else begin
        nxt = '0;
      end
    end
  end

  always_comb begin
    ans_d  = STICKY ? (state == DONE_S) : hit_q;
    prog_d = state;
  end

  assign bus.ans      = ans_d;
  assign bus.hit      = hit_q;
  assign bus.progress = prog_d;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .inc   (match),
    .q     (bus.count)
  );
endmodule

// File: doc/seq_counting.md
Name: seq_counting

Overview:
- Parametrised successor to the 2-bit "1,2,3" detector.
- Watches a stream of W-bit symbols, qualified by a valid strobe.
- Detects the ascending run 1,2,...,LEN and reports it in one of two modes:
  - sticky: lock on the first match;
  - counting: re-arm after every match and count matches.
- Sits in the pre-lab counting family as a standalone FSM feeding status LEDs or a checker.

Parameters:
- W, 2: symbol width in bits.
- LEN, 3: pattern length; the pattern is 1,2,...,LEN. Legal range is 1 <= LEN <= 2**W-1 (elaboration error otherwise).
- CNT_W, 8: width of the match counter.
- STICKY, 1: 1 = lock after the first match until clr; 0 = re-arm and count.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- en, input, 1: num is sampled only when en=1.
- num, input, W: input symbol.
- clr, input, 1: synchronous clear of state, count, ans and hit.
- ans, output, 1: match flag. Level in sticky mode; equals hit in counting mode.
- hit, output, 1: one-cycle pulse per completed match.
- count, output, CNT_W: number of matches, saturating.
- progress, output, clog2(LEN+1): number of pattern symbols currently matched.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - progress=0, state MATCH_0, ans=0, hit=0, count=0.
  - Reset asserted mid-sequence discards partial progress.
- States:
  - MATCH_k for k=0..LEN-1, meaning k symbols matched.
  - DONE, which exists only when STICKY=1.
  - progress = k; progress = LEN in DONE.
- Transition on a rising edge with en=1, from MATCH_k:
  - num == k+1: if k+1 < LEN, go to MATCH_(k+1); if k+1 == LEN, it is a match.
  - else if num == 1: go to MATCH_1. If LEN==1, this is itself a match.
  - else: go to MATCH_0.
  - The mismatch fallback is always to MATCH_1 or MATCH_0; no other suffix of 1..LEN is a prefix, so this is exact.
- On a match:
  - hit=1 for exactly the cycle following the edge that sampled the completing symbol.
  - count increments by 1 and saturates at 2**CNT_W-1 (never wraps).
  - STICKY=1: next state DONE; ans=1 and stays 1.
  - STICKY=0: next state MATCH_0 (non-overlapping; none is possible for LEN >= 2); ans mirrors hit.
- DONE (sticky only):
  - All num ignored; hit=0 after its pulse; count frozen.
  - ans=1 until clr or reset.
- en=0: state, count and ans hold; hit=0.
- clr=1 (synchronous): same values as reset. clr has priority over en/num on the same edge; a completing symbol on that edge is dropped, with no hit and no count.
- Latency: one cycle from the sampling edge to the ans/hit/progress update. All outputs are registered or decoded from registered state only, with no combinational path from num.
- Illegal num values (0 or > LEN) take the "else" branch; not an error.

Decomposition:
- Package seq_counting_pkg holds:
  - localparam function for progress width, clog2(LEN+1);
  - state encoding: MATCH_k = k, DONE = LEN;
  - symbol constant SYM_START = 1.
- Sub-module sat_counter (parameter CNT_W; ports clk, reset, clr, inc, q) implements the saturating match counter. The FSM stays in seq_counting.

Test Plan:
1. Default params, en=1, num stream 1,2,3,0 -> hit=1 one cycle after the '3' edge; ans=1 from then on; count=1; progress=3. A following 1,2,3 gives no second hit and count stays 1.
2. Default params, stream 1,1,2,2,1,2,0 -> progress sequence 1,1,2,0,1,2,0; no hit. Checks the 1-restart, mismatch-to-0, and 2 in state 2 going to 0. Ending the stream 1,2,3 gives hit.
3. STICKY=0, W=3, LEN=5, stream (1,2,3,4,5)x3 with en=0 gaps inserted mid-pattern -> three hit pulses, count=3, ans pulses coincide with hit, progress unaffected during en=0 cycles.
4. STICKY=0, CNT_W=2, five matches of 1,2,3 -> count 1,2,3,3,3 (saturates); hit still pulses 5 times.
5. Assert reset asynchronously (off-edge) after 1,2 -> progress, count and ans drop to 0 immediately. After release, 3 alone gives no hit; 1,2,3 gives hit.
6. clr=1 on the same edge as the completing '3' -> no hit, count unchanged from 0, progress=0. clr while in DONE -> ans=0 next cycle.
